mc_latency_tracker: RTL and testbench

Parametrised multi-cycle completion tracker that sits between the execute-stage issue logic and the fixed-latency pipelined functional units (IMul, FPAddSub, FPMul, FPDiv, FPItoF, FPFtoI). It accepts one tagged operation per cycle with a per-op latency and delivers each completion exactly when the functional-unit result is valid. It returns the writeback tag alongside the result. In pipelined mode it keeps several ops in flight; in blocking mode it stalls issue until the current op drains.

---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_slot_line.sv | 30 +++
 rtl/mc_latency_tracker.sv | 100 ++++++++++
 tb/tb_mc_latency_tracker.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared latency constants and sizing helpers for the multi-cycle
// completion tracker and the execute-stage functional units.
package mc_pkg;

  localparam int unsigned MC_MAX_LAT = 8;

  localparam int unsigned LAT_IMUL = 6;
  localparam int unsigned LAT_FADD = 6;
  localparam int unsigned LAT_FSUB = 6;
  localparam int unsigned LAT_FMUL = 4;
  localparam int unsigned LAT_FDIV = 5;
  localparam int unsigned LAT_ITOF = 6;
  localparam int unsigned LAT_FTOI = 6;
  localparam int unsigned LAT_COMB = 0;

  typedef enum logic [2:0] {
    FU_COMB,
    FU_IMUL,
    FU_FADD,
    FU_FSUB,
    FU_FMUL,
    FU_FDIV,
    FU_ITOF,
    FU_FTOI
  } fu_e;

  // Width needed to encode latencies 0..max inclusive.
  function automatic int unsigned lat_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

  function automatic int unsigned fu_lat(input fu_e fu);
    case (fu)
      FU_IMUL: return LAT_IMUL;
      FU_FADD: return LAT_FADD;
      FU_FSUB: return LAT_FSUB;
      FU_FMUL: return LAT_FMUL;
      FU_FDIV: return LAT_FDIV;
      FU_ITOF: return LAT_ITOF;
      FU_FTOI: return LAT_FTOI;
      default: return LAT_COMB;
    endcase
  endfunction

endpackage

// File: rtl/mc_slot_line.sv
// One completion slot: occupancy bit plus writeback tag, shifted down one
// position per cycle or loaded by a new issue.
module mc_slot_line #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             occ_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             occ,
  output logic [TAG_W-1:0] tag
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occ <= 1'b0;
      tag <= '0;
    end else if (load) begin
      occ <= 1'b1;
      tag <= load_tag;
    end else begin
      occ <= occ_in;
      tag <= tag_in;
    end
  end

endmodule

// File: rtl/mc_latency_tracker.sv
// Tracks fixed-latency ops in flight and presents each completion, with its
// writeback tag, in the cycle the functional-unit result is valid.
module mc_latency_tracker
  import mc_pkg::*;
#(
  parameter int unsigned MAX_LAT   = MC_MAX_LAT,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter bit          PIPELINED = 1'b1,
  localparam int unsigned LAT_W    = lat_w(MAX_LAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              issue_ready,
  output logic              lat_err,
  input  logic [DATA_W-1:0] fu_result,
  output logic              done_valid,
  output logic [TAG_W-1:0]  done_tag,
  output logic [DATA_W-1:0] done_data,
  output logic              busy
);

  logic [MAX_LAT-1:0] occ;
  logic [TAG_W-1:0]   tag_q [MAX_LAT];
  logic [MAX_LAT-1:0] load;
  logic               slot_hit;
  logic               upper_busy;
  logic               accept;
  logic               comb_done;

  always_comb begin
    lat_err    = issue_valid && (issue_lat > LAT_W'(MAX_LAT));
    slot_hit   = 1'b0;
    upper_busy = 1'b0;
    // occ[L] is the slot that shifts into L-1 at the load edge; occ[0] is
    // the writeback port an L=0 op would share this cycle.
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      if (occ[k] && (issue_lat == LAT_W'(k))) slot_hit = 1'b1;
      if ((k >= 1) && occ[k]) upper_busy = 1'b1;
    end
    issue_ready = !rst && !flush && !lat_err && !slot_hit &&
                  !(!PIPELINED && upper_busy);
    accept    = issue_valid && issue_ready;
    comb_done = accept && (issue_lat == '0);
    load      = '0;
    for (int unsigned k = 0; k < MAX_LAT; k++) begin
      if (accept && (issue_lat == LAT_W'(k + 1))) load[k] = 1'b1;
    end
  end

  always_comb begin
    done_valid = 1'b0;
    done_tag   = '0;
    done_data  = '0;
    if (!rst && !flush) begin
      if (comb_done) begin
        done_valid = 1'b1;
        done_tag   = issue_tag;
        done_data  = fu_result;
      end else if (occ[0]) begin
        done_valid = 1'b1;
        done_tag   = tag_q[0];
        done_data  = fu_result;
      end
    end
    busy = |occ;
  end

  for (genvar k = 0; k < MAX_LAT; k++) begin : g_slot
    logic             occ_in;
    logic [TAG_W-1:0] tag_in;

    if (k == MAX_LAT - 1) begin : g_top
      assign occ_in = 1'b0;
      assign tag_in = '0;
    end else begin : g_mid
      assign occ_in = occ[k+1];
      assign tag_in = tag_q[k+1];
    end

    mc_slot_line #(
      .TAG_W(TAG_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .load     (load[k]),
      .load_tag (issue_tag),
      .occ_in   (occ_in),
      .tag_in   (tag_in),
      .occ      (occ[k]),
      .tag      (tag_q[k])
    );
  end

endmodule

// File: tb/tb_mc_latency_tracker.sv
// Directed bench for mc_latency_tracker: a pipelined instance and a blocking
// instance driven from one scripted initial block.
module tb_mc_latency_tracker;

  logic        clk;
  logic        rst;
  logic        flush;

  logic        a_valid, a_ready, a_err, a_dv, a_busy;
  logic [3:0]  a_lat, a_tag, a_dt;
  logic [31:0] a_fu, a_dd;

  logic        b_valid, b_ready, b_err, b_dv, b_busy;
  logic [3:0]  b_lat, b_tag, b_dt;
  logic [31:0] b_fu, b_dd;

  int checks;
  int failures;

  mc_latency_tracker #(
    .MAX_LAT   (8),
    .TAG_W     (4),
    .DATA_W    (32),
    .PIPELINED (1'b1)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (a_valid),
    .issue_lat   (a_lat),
    .issue_tag   (a_tag),
    .issue_ready (a_ready),
    .lat_err     (a_err),
    .fu_result   (a_fu),
    .done_valid  (a_dv),
    .done_tag    (a_dt),
    .done_data   (a_dd),
    .busy        (a_busy)
  );

  mc_latency_tracker #(
    .MAX_LAT   (8),
    .TAG_W     (4),
    .DATA_W    (32),
    .PIPELINED (1'b0)
  ) u_block (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (b_valid),
    .issue_lat   (b_lat),
    .issue_tag   (b_tag),
    .issue_ready (b_ready),
    .lat_err     (b_err),
    .fu_result   (b_fu),
    .done_valid  (b_dv),
    .done_tag    (b_dt),
    .done_data   (b_dd),
    .busy        (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_valid = 1'b0; a_lat = '0; a_tag = '0; a_fu = '0;
    b_valid = 1'b0; b_lat = '0; b_tag = '0; b_fu = '0;
    flush   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 1'b1; a_lat = 4'd3; a_tag = 4'd7; a_fu = 32'h1234;
    b_valid = 1'b1; b_lat = 4'd3; b_tag = 4'd7; b_fu = 32'h1234;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready c=%0d got=%0b exp=0", c, a_ready); end
      checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready c=%0d got=%0b exp=0", c, b_ready); end
      checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL rst_a_dv c=%0d got=%0b exp=0", c, a_dv); end
      if (c == 1) begin
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_a_busy got=%0b exp=0", a_busy); end
        checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_b_busy got=%0b exp=0", b_busy); end
        checks++; if (a_dt !== 4'd0 || a_dd !== 32'd0) begin failures++; $display("FAIL rst_a_done got=%h/%h exp=0/0", a_dt, a_dd); end
      end
      tick;
    end
    rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rel_a_ready got=%0b exp=1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL rel_b_ready got=%0b exp=1", b_ready); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rel_a_busy got=%0b exp=0", a_busy); end
    idle_inputs();
    tick;
  endtask

  task automatic test_mid_reset;
    a_valid = 1'b1; a_lat = 4'd2; a_tag = 4'd4;
    tick;
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL midrst_dv_during got=%0b exp=0", a_dv); end
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL midrst_dv c=%0d got=%0b exp=0", c, a_dv); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy c=%0d got=%0b exp=0", c, a_busy); end
      tick;
    end
  endtask

  task automatic test_single;
    a_valid = 1'b1; a_lat = 4'd6; a_tag = 4'h5; a_fu = 32'h0;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", a_ready); end
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL single_dv0 got=%0b exp=0", a_dv); end
    tick;
    a_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      a_fu = (c == 6) ? 32'hDEADBEEF : 32'h100 + c;
      #1;
      checks++; if (a_dv !== (c == 6)) begin failures++; $display("FAIL single_dv c=%0d got=%0b exp=%0b", c, a_dv, (c == 6)); end
      checks++; if (a_busy !== (c <= 6)) begin failures++; $display("FAIL single_busy c=%0d got=%0b exp=%0b", c, a_busy, (c <= 6)); end
      if (c == 6) begin
        checks++; if (a_dt !== 4'h5) begin failures++; $display("FAIL single_tag got=%h exp=5", a_dt); end
        checks++; if (a_dd !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", a_dd); end
      end else begin
        checks++; if (a_dd !== 32'h0) begin failures++; $display("FAIL single_data0 c=%0d got=%h exp=0", c, a_dd); end
      end
      tick;
    end
  endtask

  task automatic test_comb;
    a_valid = 1'b1; a_lat = 4'd1; a_tag = 4'd3; a_fu = 32'h0;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL comb_l1_ready got=%0b exp=1", a_ready); end
    tick;
    a_lat = 4'd0; a_tag = 4'd9; a_fu = 32'hAAAA_AAAA;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL comb_port_conflict got=%0b exp=0", a_ready); end
    checks++; if (a_dv !== 1'b1 || a_dt !== 4'd3) begin failures++; $display("FAIL comb_tracked got=%0b/%h exp=1/3", a_dv, a_dt); end
    tick;
    a_fu = 32'h5555_5555;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL comb_ready got=%0b exp=1", a_ready); end
    checks++; if (a_dv !== 1'b1 || a_dt !== 4'd9) begin failures++; $display("FAIL comb_done got=%0b/%h exp=1/9", a_dv, a_dt); end
    checks++; if (a_dd !== 32'h5555_5555) begin failures++; $display("FAIL comb_data got=%h exp=55555555", a_dd); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL comb_busy got=%0b exp=0", a_busy); end
    tick;
    a_valid = 1'b0;
    #1;
    checks++; if (a_dv !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL comb_after got=%0b/%0b exp=0/0", a_dv, a_busy); end
    tick;
  endtask

  task automatic test_collision;
    a_valid = 1'b1; a_lat = 4'd6; a_tag = 4'd1;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL coll_first got=%0b exp=1", a_ready); end
    tick;
    a_lat = 4'd5; a_tag = 4'd2;
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL coll_block got=%0b exp=0", a_ready); end
    tick;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL coll_accept got=%0b exp=1", a_ready); end
    tick;
    a_valid = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      #1;
      checks++; if (a_dv !== (c == 6 || c == 7)) begin failures++; $display("FAIL coll_dv c=%0d got=%0b exp=%0b", c, a_dv, (c == 6 || c == 7)); end
      if (c == 6 || c == 7) begin
        checks++; if (a_dt !== ((c == 6) ? 4'd1 : 4'd2)) begin failures++; $display("FAIL coll_tag c=%0d got=%h exp=%h", c, a_dt, (c == 6) ? 4'd1 : 4'd2); end
      end
      tick;
    end
  endtask

  task automatic test_pipelined;
    for (int c = 0; c <= 9; c++) begin
      a_valid = (c < 3);
      a_lat   = 4'(4 + c);
      a_tag   = 4'(10 + c);
      a_fu    = 32'hF000 + c;
      #1;
      if (c < 3) begin
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL pipe_ready c=%0d got=%0b exp=1", c, a_ready); end
      end
      checks++; if (a_dv !== (c == 4 || c == 6 || c == 8)) begin failures++; $display("FAIL pipe_dv c=%0d got=%0b exp=%0b", c, a_dv, (c == 4 || c == 6 || c == 8)); end
      if (c == 4 || c == 6 || c == 8) begin
        checks++; if (a_dt !== ((c == 4) ? 4'd10 : (c == 6) ? 4'd11 : 4'd12)) begin failures++; $display("FAIL pipe_tag c=%0d got=%h", c, a_dt); end
        checks++; if (a_dd !== 32'hF000 + c) begin failures++; $display("FAIL pipe_data c=%0d got=%h exp=%h", c, a_dd, 32'hF000 + c); end
      end
      tick;
    end
    a_valid = 1'b0;
  endtask

  task automatic test_lat_err;
    a_valid = 1'b0; a_lat = 4'd9;
    #1;
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL err_novalid got=%0b exp=0", a_err); end
    a_valid = 1'b1;
    #1;
    checks++; if (a_err !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL err_l9 got=%0b/%0b exp=1/0", a_err, a_ready); end
    a_lat = 4'd8; a_tag = 4'd1;
    #1;
    checks++; if (a_err !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL err_l8 got=%0b/%0b exp=0/1", a_err, a_ready); end
    tick;
    a_tag = 4'd2;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL maxlat_back2back got=%0b exp=1", a_ready); end
    tick;
    a_valid = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      #1;
      checks++; if (a_dv !== (c == 8 || c == 9)) begin failures++; $display("FAIL maxlat_dv c=%0d got=%0b exp=%0b", c, a_dv, (c == 8 || c == 9)); end
      tick;
    end
  endtask

  task automatic test_blocking;
    b_valid = 1'b1; b_lat = 4'd4; b_tag = 4'd6; b_fu = 32'h0;
    #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL blk_first got=%0b exp=1", b_ready); end
    tick;
    b_lat = 4'd2; b_tag = 4'd7;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL blk_stall c=%0d got=%0b exp=0", c, b_ready); end
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL blk_busy c=%0d got=%0b exp=1", c, b_busy); end
      tick;
    end
    b_fu = 32'hB0B0;
    #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL blk_accept got=%0b exp=1", b_ready); end
    checks++; if (b_dv !== 1'b1 || b_dt !== 4'd6 || b_dd !== 32'hB0B0) begin failures++; $display("FAIL blk_done1 got=%0b/%h/%h exp=1/6/b0b0", b_dv, b_dt, b_dd); end
    tick;
    b_valid = 1'b0;
    #1;
    checks++; if (b_dv !== 1'b0) begin failures++; $display("FAIL blk_gap got=%0b exp=0", b_dv); end
    tick;
    b_fu = 32'hC0C0;
    #1;
    checks++; if (b_dv !== 1'b1 || b_dt !== 4'd7 || b_dd !== 32'hC0C0) begin failures++; $display("FAIL blk_done2 got=%0b/%h/%h exp=1/7/c0c0", b_dv, b_dt, b_dd); end
    tick;
    #1;
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL blk_drained got=%0b exp=0", b_busy); end
  endtask

  task automatic test_flush;
    a_valid = 1'b1; a_lat = 4'd7; a_tag = 4'd1;
    tick;
    a_lat = 4'd2; a_tag = 4'd2;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL flush_setup got=%0b exp=1", a_ready); end
    tick;
    a_valid = 1'b0;
    tick;
    flush = 1'b1; a_valid = 1'b1; a_lat = 4'd3;
    #1;
    checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL flush_dv got=%0b exp=0", a_dv); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL flush_busy_pre got=%0b exp=1", a_busy); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", a_ready); end
    tick;
    flush = 1'b0; a_valid = 1'b0;
    for (int c = 4; c <= 10; c++) begin
      #1;
      checks++; if (a_dv !== 1'b0) begin failures++; $display("FAIL flush_after_dv c=%0d got=%0b exp=0", c, a_dv); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL flush_after_busy c=%0d got=%0b exp=0", c, a_busy); end
      tick;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_mid_reset();
    test_single();
    test_comb();
    test_collision();
    test_pipelined();
    test_lat_err();
    test_blocking();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
